// File: rtl/reg_share_pkg.sv
// rtl/reg_share_pkg.sv - shared constants, state encodings and winner search for reg_share_arbiter
package reg_share_pkg;

   localparam int NREQ    = 4;
   localparam int OWNER_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   // First asserted request at or after start, wrapping 3 -> 0.
   // With start fixed at 0 this is plain fixed priority (req[0] highest).
   function automatic logic [OWNER_W-1:0] pick_winner(
      input logic [NREQ-1:0]    req,
      input logic [OWNER_W-1:0] start
   );
      logic [OWNER_W-1:0] idx;
      logic [OWNER_W-1:0] win;
      logic               found;
      win   = start;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = start + OWNER_W'(k);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/reg_en_dff.sv
// rtl/reg_en_dff.sv - WIDTH-bit enabled D-flip-flop register with async active-low clear
module reg_en_dff #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Load d when enabled; clear immediately on clr_n low.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/reg_share_arbiter.sv
// rtl/reg_share_arbiter.sv - arbiter/write sequencer for one shared register; ARB_ROUND_ROBIN_EN selects round-robin
module reg_share_arbiter
   import reg_share_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] wdata,
   output logic [NREQ-1:0]       gnt,
   output logic [OWNER_W-1:0]    owner,
   output logic                  busy,
   output logic                  wr_done,
   output logic [WIDTH-1:0]      q
);

   state_t             state;
   state_t             state_nxt;
   logic [NREQ-1:0]    gnt_nxt;
   logic [OWNER_W-1:0] owner_nxt;
   logic               busy_nxt;
   logic               wr_done_nxt;
   logic [OWNER_W-1:0] win;
   logic [OWNER_W-1:0] ptr;
   logic               load_en;

`ifdef ARB_ROUND_ROBIN_EN
   // Search pointer moves just past the owner after every completed write;
   // aborts never reach WRITE, so they leave it alone.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (state == ST_WRITE) begin
         ptr <= owner + 1'b1;
      end
   end
`else
   assign ptr = '0;
`endif

   assign win     = pick_winner(req, ptr);
   assign load_en = (state == ST_GRANT) && req[owner];

   // Next state and next registered outputs; defaults hold everything but the wr_done pulse.
   always_comb begin
      state_nxt   = ST_IDLE;
      gnt_nxt     = gnt;
      owner_nxt   = owner;
      busy_nxt    = busy;
      wr_done_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|req) begin
               state_nxt      = ST_GRANT;
               gnt_nxt        = '0;
               gnt_nxt[win]   = 1'b1;
               owner_nxt      = win;
               busy_nxt       = 1'b1;
            end
         end
         ST_GRANT: begin
            if (req[owner]) begin
               state_nxt   = ST_WRITE;
               wr_done_nxt = 1'b1;
            end else begin
               gnt_nxt  = '0;
               busy_nxt = 1'b0;
            end
         end
         ST_WRITE: begin
            gnt_nxt  = '0;
            busy_nxt = 1'b0;
         end
         default: begin
            gnt_nxt  = '0;
            busy_nxt = 1'b0;
         end
      endcase
   end

   // State and handshake output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         gnt     <= '0;
         owner   <= '0;
         busy    <= 1'b0;
         wr_done <= 1'b0;
      end else begin
         state   <= state_nxt;
         gnt     <= gnt_nxt;
         owner   <= owner_nxt;
         busy    <= busy_nxt;
         wr_done <= wr_done_nxt;
      end
   end

   reg_en_dff #(
      .WIDTH (WIDTH)
   ) u_reg (
      .clk   (clk),
      .clr_n (reset_n),
      .en    (load_en),
      .d     (wdata[owner*WIDTH +: WIDTH]),
      .q     (q)
   );

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb/tb_reg_share_arbiter.sv - self-checking bench for reg_share_arbiter
module tb_reg_share_arbiter;

   logic        clk;
   logic        reset_n;
   logic [3:0]  req;
   logic [31:0] wdata;
   logic [3:0]  gnt;
   logic [1:0]  owner;
   logic        busy;
   logic        wr_done;
   logic [7:0]  q;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] wdata;
      logic [3:0]  exp_gnt;
      logic [1:0]  exp_owner;
      logic [7:0]  exp_q;
   } vec_t;

   typedef struct {
      logic [1:0] owner;
      logic [7:0] data;
   } sb_t;

   vec_t vec[6];
   sb_t  sb[$];
   logic [7:0] last_q;

   reg_share_arbiter #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .wdata   (wdata),
      .gnt     (gnt),
      .owner   (owner),
      .busy    (busy),
      .wr_done (wr_done),
      .q       (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every wr_done must match the oldest pending expectation; gnt is never multi-hot.
   always @(negedge clk) begin
      if (reset_n) begin
         n_total++;
         if ($onehot0(gnt)) n_pass++;
         else $display("FAIL gnt_onehot: got %b expected at most one bit", gnt);
         if (wr_done) begin
            n_total++;
            if (sb.size() == 0) begin
               $display("FAIL sb_unexpected_wr_done: got owner %0d q %0h expected no write", owner, q);
            end else begin
               sb_t e;
               e = sb.pop_front();
               if (owner === e.owner && q === e.data) n_pass++;
               else $display("FAIL sb_write: got owner %0d q %0h expected owner %0d q %0h",
                             owner, q, e.owner, e.data);
            end
         end
      end
   end

   initial begin
      vec[0] = '{4'b0100, 32'h00A5_0000, 4'b0100, 2'd2, 8'hA5};
      vec[1] = '{4'b0001, 32'h0000_003C, 4'b0001, 2'd0, 8'h3C};
      vec[2] = '{4'b1000, 32'hC300_0000, 4'b1000, 2'd3, 8'hC3};
      vec[3] = '{4'b0010, 32'h0000_5A00, 4'b0010, 2'd1, 8'h5A};
`ifdef ARB_ROUND_ROBIN_EN
      vec[4] = '{4'b0110, 32'h0099_6600, 4'b0100, 2'd2, 8'h99};
      vec[5] = '{4'b1001, 32'h7E00_00E1, 4'b1000, 2'd3, 8'h7E};
`else
      vec[4] = '{4'b0110, 32'h0099_6600, 4'b0010, 2'd1, 8'h66};
      vec[5] = '{4'b1001, 32'h7E00_00E1, 4'b0001, 2'd0, 8'hE1};
`endif

      // Reset: two cycles low, everything zero.
      reset_n = 1'b0;
      req     = '0;
      wdata   = '0;
      step();
      step();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_owner", 32'(owner), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_wr_done", 32'(wr_done), 0);
      chk("rst_q", 32'(q), 0);
      reset_n = 1'b1;
      last_q  = 8'h00;
      step();

      // Table-driven single transactions.
      for (int i = 0; i < 6; i++) begin
         wdata = vec[i].wdata;
         req   = vec[i].req;
         sb.push_back('{vec[i].exp_owner, vec[i].exp_q});
         step();
         chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vec[i].exp_gnt));
         chk($sformatf("v%0d_owner", i), 32'(owner), 32'(vec[i].exp_owner));
         chk($sformatf("v%0d_busy", i), 32'(busy), 1);
         chk($sformatf("v%0d_q_hold", i), 32'(q), 32'(last_q));
         step();
         chk($sformatf("v%0d_q", i), 32'(q), 32'(vec[i].exp_q));
         chk($sformatf("v%0d_wr_done", i), 32'(wr_done), 1);
         last_q = vec[i].exp_q;
         req = '0;
         step();
         chk($sformatf("v%0d_gnt_off", i), 32'(gnt), 0);
         chk($sformatf("v%0d_busy_off", i), 32'(busy), 0);
         chk($sformatf("v%0d_wr_done_off", i), 32'(wr_done), 0);
      end

      // Contention: all four held high from reset.
      reset_n = 1'b0;
      req     = 4'b1111;
      wdata   = 32'h4332_2110;
      step();
      step();
      reset_n = 1'b1;
      last_q  = 8'h00;
      for (int t = 0; t < 5; t++) begin
         logic [1:0] eo;
         logic [7:0] ed;
`ifdef ARB_ROUND_ROBIN_EN
         eo = 2'(t % 4);
`else
         eo = 2'd0;
`endif
         ed = 8'(wdata >> (8 * eo));
         sb.push_back('{eo, ed});
         step();
         chk($sformatf("ct%0d_owner", t), 32'(owner), 32'(eo));
         chk($sformatf("ct%0d_gnt", t), 32'(gnt), 32'(4'b0001 << eo));
         step();
         chk($sformatf("ct%0d_q", t), 32'(q), 32'(ed));
         chk($sformatf("ct%0d_wr_done", t), 32'(wr_done), 1);
         last_q = ed;
         step();
         chk($sformatf("ct%0d_idle", t), 32'(busy), 0);
      end
      req = '0;
      step();

      // Abort: drop req[1] while granted.
      wdata = 32'h0000_7700;
      req   = 4'b0010;
      step();
      chk("ab_gnt", 32'(gnt), 32'(4'b0010));
      req = '0;
      step();
      chk("ab_busy", 32'(busy), 0);
      chk("ab_gnt_off", 32'(gnt), 0);
      chk("ab_wr_done", 32'(wr_done), 0);
      chk("ab_q", 32'(q), 32'(last_q));
      req = 4'b0010;
      sb.push_back('{2'd1, 8'h77});
      step();
      chk("ab_regnt", 32'(gnt), 32'(4'b0010));
      step();
      chk("ab_req_q", 32'(q), 32'h77);
      req = '0;
      step();
      last_q = 8'h77;

      // Mid-transaction reset with q previously 8'hFF.
      wdata = 32'h0011_00FF;
      req   = 4'b0001;
      sb.push_back('{2'd0, 8'hFF});
      step();
      step();
      chk("mr_q_ff", 32'(q), 32'hFF);
      req = '0;
      step();
      req = 4'b0100;
      step();
      chk("mr_grant", 32'(gnt), 32'(4'b0100));
      #2 reset_n = 1'b0;
      #1;
      chk("mr_q_clr", 32'(q), 0);
      chk("mr_gnt_clr", 32'(gnt), 0);
      chk("mr_busy_clr", 32'(busy), 0);
      step();
      chk("mr_wr_done", 32'(wr_done), 0);
      reset_n = 1'b1;
      req     = '0;
      last_q  = 8'h00;
      step();
      chk("mr_idle_gnt", 32'(gnt), 0);
      chk("mr_idle_busy", 32'(busy), 0);

      // Late arrival of req[3] during an owner-0 transaction.
      wdata = 32'hD300_005C;
      req   = 4'b0001;
      sb.push_back('{2'd0, 8'h5C});
      step();
      chk("la_gnt0", 32'(gnt), 32'(4'b0001));
      req = 4'b1001;
      sb.push_back('{2'd3, 8'hD3});
      step();
      chk("la_gnt_hold", 32'(gnt), 32'(4'b0001));
      chk("la_q0", 32'(q), 32'h5C);
      req = 4'b1000;
      step();
      chk("la_gnt_off", 32'(gnt), 0);
      step();
      chk("la_gnt3", 32'(gnt), 32'(4'b1000));
      chk("la_owner3", 32'(owner), 3);
      step();
      chk("la_q3", 32'(q), 32'hD3);
      req = '0;
      step();
      chk("la_done", 32'(busy), 0);
      step();

      chk("sb_drained", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
